input_checker: RTL and testbench
================================

# input_checker

Captures the player's answer in the Simon Says game and checks it against the stored sequence. `blinker` plays a sequence out of `simple_memory` onto the LEDs; this block is the other direction. It debounces the four push-buttons and encodes each press to a 2-bit code. It compares each code against the `simple_memory` entry at address `count` and reports `done` (whole sequence matched) or `fail` (wrong button or timeout) to the game FSM.

## Interface
- `DEBOUNCE_CYC`, default 1_000_000: cycles a button level must stay stable to be accepted (20 ms at 50 MHz).
- `TIMEOUT_CYC`, default 250_000_000: cycles allowed in WAIT_PRESS before the attempt fails (5 s at 50 MHz).

- `clk`, input, 1: system clock, 50 MHz.
- `reset`, input, 1: asynchronous, active-low reset.
- `on_off`, input, 1: enable from the FSM. Low forces IDLE.
- `level`, input, 4: number of entries to check. Valid range is 1..10.
- `btn`, input, 4: raw push-buttons, active-high, already synchronised to `clk`.
- `expected`, input, 2: `simple_memory` read data for address `count`.
- `count`, output, 4: `simple_memory` read address, which is also the number of entries matched so far.
- `done`, output, 1: sequence fully matched. Sticky until leaving PASS.
- `fail`, output, 1: mismatch or timeout. Sticky until leaving FAIL.
- `led_out`, output, 10: echo of the accepted button, driven as `{6'd0, onehot}`.

## Operation
- Reset values: all outputs are 0 and the state is IDLE.
- Button code mapping: `btn[0]`→0, `btn[1]`→1, `btn[2]`→2, `btn[3]`→3. This is the inverse of the `decoder_2_4` mapping.
- States:
  - **IDLE**: `count`=0, `done`=0, `fail`=0, `led_out`=0. Moves to WAIT_PRESS when `on_off`=1 and 1≤`level`≤10. Otherwise it stays in IDLE.
  - **WAIT_PRESS**: waits for `btn` to be one-hot. Zero buttons or more than one button are ignored. On a one-hot value it latches the code and the one-hot vector, clears the debounce counter, and moves to DEBOUNCE.
  - **DEBOUNCE**: if `btn` ≠ the latched vector, it returns to WAIT_PRESS. When the counter reaches `DEBOUNCE_CYC`, it moves to CHECK.
  - **CHECK**: a single cycle.
    - If code == `expected`, it sets `led_out` and moves to WAIT_RELEASE.
    - Otherwise it moves to FAIL.
  - **WAIT_RELEASE**: `led_out` stays on. The counter runs while `btn`==0 and restarts on any nonzero `btn`. When the counter reaches `DEBOUNCE_CYC`, the block clears `led_out` and increments `count`.
    - If `count`+1 == `level`, it moves to PASS.
    - Otherwise it moves to WAIT_PRESS.
  - **PASS**: `done`=1 and `count` is held. It leaves only when `on_off`=0.
  - **FAIL**: `fail`=1 and `count` is held at the index of the failing entry. It leaves only when `on_off`=0.
- `on_off`=0 in any state moves the block to IDLE on the next edge. The IDLE clears apply on that same edge.
- `level` is sampled on leaving IDLE and latched. Later changes to `level` are ignored until the block returns to IDLE.
- Counters are 32-bit and saturate. They never wrap.

## Timing
- Minimum cycles from the press edge to `led_out` asserting: `DEBOUNCE_CYC`+2. This is 1 cycle in WAIT_PRESS, `DEBOUNCE_CYC` cycles in DEBOUNCE, and 1 cycle in CHECK.
- `expected` must be valid while `count` is stable. `simple_memory` reads combinationally, so `expected` is ready by CHECK.
- `count` increments exactly once per accepted press+release, on the edge that leaves WAIT_RELEASE.
- `done` and `fail` assert on the edge that enters PASS or FAIL. They are never high together.
- `reset` low clears all state immediately, without waiting for a clock edge, including in the middle of a debounce.

## Configuration
- `INPUT_CHECKER_TIMEOUT_EN`:
  - **Defined**: a timeout counter runs in WAIT_PRESS and is cleared on entering WAIT_PRESS. When it reaches `TIMEOUT_CYC`, the block goes to FAIL with `count` unchanged.
  - **Undefined**: the counter logic is absent and WAIT_PRESS waits indefinitely. `TIMEOUT_CYC` is ignored.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4 and `TIMEOUT_CYC`=100.
- **Full match**: `level`=3, memory={2,0,3}, clean presses `btn`=4'b0100, 0001, 1000. Required: `count` steps 0→1→2→3, `led_out`=10'h004 then 10'h001 then 10'h008, then `done`=1 and `fail`=0.
- **Mismatch**: `level`=3, memory={1,1,1}, second press `btn`=4'b0010 then `btn`=4'b0100. Required: `fail`=1 with `count`=1, `done`=0.
- **Bounce**: `btn` toggles 0010/0000 every 2 cycles, then is held for 10 cycles. Required: only one CHECK occurs and `count` advances by exactly 1.
- **Multi-press ignored**: `btn`=4'b0011 for 50 cycles, then 4'b0010. Required: no `led_out` during 0011, and the 0010 press is accepted normally.
- **Timeout**: with the macro defined, no press for 101 cycles. Required: `fail`=1 and `count`=0. With the macro undefined, `fail` stays 0.
- **Abort**: deassert `on_off` during DEBOUNCE, then assert `reset`=0 during WAIT_RELEASE. Required: IDLE values (`count`=0, `led_out`=0) at the next edge and immediately on `reset`, respectively. Also, `level`=0 or `level`=11 keeps the block in IDLE.

Source files
------------

// File: rtl/input_checker_if.sv
// Button/answer bus between the Simon Says game FSM and input_checker.
// master = game FSM side (enable, level, buttons, memory data); slave = input_checker.
interface input_checker_if;
    logic       on_off;
    logic [3:0] level;
    logic [3:0] btn;
    logic [1:0] expected;
    logic [3:0] count;
    logic       done;
    logic       fail;
    logic [9:0] led_out;

    modport master (
        output on_off, level, btn, expected,
        input  count, done, fail, led_out
    );

    modport slave (
        input  on_off, level, btn, expected,
        output count, done, fail, led_out
    );
endinterface

// File: rtl/input_checker.sv
// Debounces player buttons, checks each press against simple_memory[count], reports done/fail.
// Optional press timeout in WAIT_PRESS is enabled by defining INPUT_CHECKER_TIMEOUT_EN.
module input_checker #(
`ifdef INPUT_CHECKER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC  = 250_000_000,
`endif
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input logic            clk,
    input logic            reset,
    input_checker_if.slave ck
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BTN_W   = 4;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned LED_W   = 10;
    localparam int unsigned LVL_MAX = 10;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WAIT_PRESS   = 3'd1;
    localparam logic [2:0] S_DEBOUNCE     = 3'd2;
    localparam logic [2:0] S_CHECK        = 3'd3;
    localparam logic [2:0] S_WAIT_RELEASE = 3'd4;
    localparam logic [2:0] S_PASS         = 3'd5;
    localparam logic [2:0] S_FAIL         = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [BTN_W-1:0]  vec_q, vec_d;
    logic [IDX_W-1:0]  level_q, level_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [LED_W-1:0]  led_q, led_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              deb_hit;
    logic              btn_onehot;
    logic [CODE_W-1:0] btn_code;
    logic              level_ok;
    logic [IDX_W-1:0]  count_inc;

`ifdef INPUT_CHECKER_TIMEOUT_EN
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  tmo_inc;
    logic              tmo_hit;

    // Saturating press-timeout counter compare
    assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + CNT_W'(1);
    assign tmo_hit = (tmo_inc >= CNT_W'(TIMEOUT_CYC));
`endif

    // Saturating debounce counter; a hit means the level has been stable long enough
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign deb_hit    = (cnt_inc >= CNT_W'(DEBOUNCE_CYC));
    assign btn_onehot = $onehot(ck.btn);
    assign level_ok   = (ck.level >= IDX_W'(1)) && (ck.level <= IDX_W'(LVL_MAX));
    assign count_inc  = count_q + IDX_W'(1);

    // One-hot button to 2-bit code (inverse of decoder_2_4)
    always_comb begin
        btn_code = '0;
        case (ck.btn)
            4'b0001: btn_code = 2'd0;
            4'b0010: btn_code = 2'd1;
            4'b0100: btn_code = 2'd2;
            4'b1000: btn_code = 2'd3;
            default: btn_code = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            vec_q   <= '0;
            level_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            led_q   <= '0;
`ifdef INPUT_CHECKER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            vec_q   <= vec_d;
            level_q <= level_d;
            count_q <= count_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            led_q   <= led_d;
`ifdef INPUT_CHECKER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        vec_d   = vec_q;
        level_d = level_q;
        count_d = count_q;
        done_d  = done_q;
        fail_d  = fail_q;
        led_d   = led_q;
`ifdef INPUT_CHECKER_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                done_d  = 1'b0;
                fail_d  = 1'b0;
                led_d   = '0;
                cnt_d   = '0;
                if (ck.on_off && level_ok) begin
                    level_d = ck.level;
                    state_d = S_WAIT_PRESS;
`ifdef INPUT_CHECKER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end

            S_WAIT_PRESS: begin
                if (btn_onehot) begin
                    code_d  = btn_code;
                    vec_d   = ck.btn;
                    cnt_d   = '0;
                    state_d = S_DEBOUNCE;
                end else begin
`ifdef INPUT_CHECKER_TIMEOUT_EN
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        fail_d  = 1'b1;
                        state_d = S_FAIL;
                    end
`endif
                end
            end

            S_DEBOUNCE: begin
                if (ck.btn != vec_q) begin
                    state_d = S_WAIT_PRESS;
`ifdef INPUT_CHECKER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                    if (deb_hit) begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                cnt_d = '0;
                if (code_q == ck.expected) begin
                    led_d   = {6'd0, vec_q};
                    state_d = S_WAIT_RELEASE;
                end else begin
                    fail_d  = 1'b1;
                    state_d = S_FAIL;
                end
            end

            // Release must be stable for the full debounce window before the entry counts
            S_WAIT_RELEASE: begin
                if (ck.btn != '0) begin
                    cnt_d = '0;
                end else if (deb_hit) begin
                    cnt_d   = '0;
                    led_d   = '0;
                    count_d = count_inc;
                    if (count_inc == level_q) begin
                        done_d  = 1'b1;
                        state_d = S_PASS;
                    end else begin
                        state_d = S_WAIT_PRESS;
`ifdef INPUT_CHECKER_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_PASS: begin
                done_d = 1'b1;
            end

            S_FAIL: begin
                fail_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable from the game FSM wins in every state, with IDLE clears on the same edge
        if (!ck.on_off) begin
            state_d = S_IDLE;
            count_d = '0;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            led_d   = '0;
            cnt_d   = '0;
        end
    end

    assign ck.count   = count_q;
    assign ck.done    = done_q;
    assign ck.fail    = fail_q;
    assign ck.led_out = led_q;

endmodule

// File: tb/tb_input_checker.sv
// Self-checking bench for input_checker with DEBOUNCE_CYC=4, TIMEOUT_CYC=100.
module tb_input_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    input_checker_if ifc ();

    logic [1:0] mem [16];
    assign ifc.expected = mem[ifc.count];

    input_checker #(
`ifdef INPUT_CHECKER_TIMEOUT_EN
        .TIMEOUT_CYC(100),
`endif
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .ck   (ifc)
    );

    logic [9:0] exp_led_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic [3:0] lvl, input logic [1:0] m0, input logic [1:0] m1,
                           input logic [1:0] m2);
        ifc.on_off = 1'b0;
        ifc.btn    = 4'd0;
        tick(2);
        mem[0] = m0;
        mem[1] = m1;
        mem[2] = m2;
        ifc.level  = lvl;
        ifc.on_off = 1'b1;
        tick(2);
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int rel);
        ifc.btn = v;
        tick(hold);
        ifc.btn = 4'd0;
        tick(rel);
    endtask

    // Scoreboard: every rising led_out pattern must match the next queued expectation
    task automatic led_monitor();
        logic [9:0] prev;
        logic [9:0] e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (ifc.led_out !== prev && ifc.led_out !== 10'd0) begin
                n_checks++;
                if (exp_led_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL led_unexpected: led_out=%h required none", ifc.led_out);
                end else begin
                    e = exp_led_q.pop_front();
                    if (ifc.led_out !== e) begin
                        n_fail++;
                        $display("FAIL led_value: led_out=%h required %h", ifc.led_out, e);
                    end
                end
            end
            prev = ifc.led_out;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.on_off = 1'b0;
        ifc.level  = 4'd0;
        ifc.btn    = 4'd0;
        tick(2);
        n_checks++; if (ifc.count !== 4'd0)    begin n_fail++; $display("FAIL reset_count: %0d required 0", ifc.count); end
        n_checks++; if (ifc.done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: %b required 0", ifc.done); end
        n_checks++; if (ifc.fail !== 1'b0)     begin n_fail++; $display("FAIL reset_fail: %b required 0", ifc.fail); end
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL reset_led: %h required 0", ifc.led_out); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_full_match();
        restart(4'd3, 2'd2, 2'd0, 2'd3);
        n_checks++; if (ifc.count !== 4'd0) begin n_fail++; $display("FAIL full_count0: %0d required 0", ifc.count); end
        exp_led_q.push_back(10'h004);
        ifc.btn = 4'b0100;
        tick(5);
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL full_latency_early: %h required 0", ifc.led_out); end
        tick(1);
        n_checks++; if (ifc.led_out !== 10'h004) begin n_fail++; $display("FAIL full_latency: %h required 004", ifc.led_out); end
        tick(2);
        ifc.btn = 4'd0;
        tick(8);
        n_checks++; if (ifc.count !== 4'd1) begin n_fail++; $display("FAIL full_count1: %0d required 1", ifc.count); end
        exp_led_q.push_back(10'h001);
        press(4'b0001, 8, 8);
        n_checks++; if (ifc.count !== 4'd2) begin n_fail++; $display("FAIL full_count2: %0d required 2", ifc.count); end
        exp_led_q.push_back(10'h008);
        press(4'b1000, 8, 8);
        n_checks++; if (ifc.count !== 4'd3)    begin n_fail++; $display("FAIL full_count3: %0d required 3", ifc.count); end
        n_checks++; if (ifc.done !== 1'b1)     begin n_fail++; $display("FAIL full_done: %b required 1", ifc.done); end
        n_checks++; if (ifc.fail !== 1'b0)     begin n_fail++; $display("FAIL full_fail: %b required 0", ifc.fail); end
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL full_led_off: %h required 0", ifc.led_out); end
    endtask

    task automatic test_mismatch();
        restart(4'd3, 2'd1, 2'd1, 2'd1);
        exp_led_q.push_back(10'h002);
        press(4'b0010, 8, 8);
        n_checks++; if (ifc.count !== 4'd1) begin n_fail++; $display("FAIL mis_count_pre: %0d required 1", ifc.count); end
        press(4'b0100, 8, 8);
        n_checks++; if (ifc.fail !== 1'b1)     begin n_fail++; $display("FAIL mis_fail: %b required 1", ifc.fail); end
        n_checks++; if (ifc.count !== 4'd1)    begin n_fail++; $display("FAIL mis_count: %0d required 1", ifc.count); end
        n_checks++; if (ifc.done !== 1'b0)     begin n_fail++; $display("FAIL mis_done: %b required 0", ifc.done); end
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL mis_led: %h required 0", ifc.led_out); end
    endtask

    task automatic test_bounce();
        restart(4'd3, 2'd1, 2'd1, 2'd1);
        exp_led_q.push_back(10'h002);
        repeat (4) begin
            ifc.btn = 4'b0010;
            tick(2);
            ifc.btn = 4'd0;
            tick(2);
        end
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL bounce_led: %h required 0", ifc.led_out); end
        n_checks++; if (ifc.count !== 4'd0)    begin n_fail++; $display("FAIL bounce_count0: %0d required 0", ifc.count); end
        press(4'b0010, 10, 8);
        n_checks++; if (ifc.count !== 4'd1) begin n_fail++; $display("FAIL bounce_count1: %0d required 1", ifc.count); end
        n_checks++; if (exp_led_q.size() != 0) begin n_fail++; $display("FAIL bounce_checks: %0d pending required 0", exp_led_q.size()); end
    endtask

    task automatic test_multi_press();
        logic [9:0] seen;
        restart(4'd3, 2'd1, 2'd1, 2'd1);
        seen = '0;
        ifc.btn = 4'b0011;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            seen |= ifc.led_out;
        end
        ifc.btn = 4'd0;
        tick(1);
        n_checks++; if (seen !== 10'd0)     begin n_fail++; $display("FAIL multi_led: %h required 0", seen); end
        n_checks++; if (ifc.count !== 4'd0) begin n_fail++; $display("FAIL multi_count0: %0d required 0", ifc.count); end
        exp_led_q.push_back(10'h002);
        press(4'b0010, 8, 8);
        n_checks++; if (ifc.count !== 4'd1) begin n_fail++; $display("FAIL multi_count1: %0d required 1", ifc.count); end
    endtask

    task automatic test_timeout();
        restart(4'd3, 2'd1, 2'd1, 2'd1);
        tick(98);
        n_checks++; if (ifc.fail !== 1'b0) begin n_fail++; $display("FAIL tmo_early: %b required 0", ifc.fail); end
        tick(2);
`ifdef INPUT_CHECKER_TIMEOUT_EN
        n_checks++; if (ifc.fail !== 1'b1) begin n_fail++; $display("FAIL tmo_fail: %b required 1", ifc.fail); end
`else
        n_checks++; if (ifc.fail !== 1'b0) begin n_fail++; $display("FAIL tmo_fail: %b required 0", ifc.fail); end
`endif
        n_checks++; if (ifc.count !== 4'd0) begin n_fail++; $display("FAIL tmo_count: %0d required 0", ifc.count); end
        n_checks++; if (ifc.done !== 1'b0)  begin n_fail++; $display("FAIL tmo_done: %b required 0", ifc.done); end
    endtask

    task automatic test_abort();
        int budget;
        restart(4'd3, 2'd1, 2'd1, 2'd1);
        exp_led_q.push_back(10'h002);
        press(4'b0010, 8, 8);
        n_checks++; if (ifc.count !== 4'd1) begin n_fail++; $display("FAIL abort_count_pre: %0d required 1", ifc.count); end
        ifc.btn = 4'b0010;
        tick(3);
        ifc.on_off = 1'b0;
        tick(1);
        n_checks++; if (ifc.count !== 4'd0)    begin n_fail++; $display("FAIL abort_off_count: %0d required 0", ifc.count); end
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL abort_off_led: %h required 0", ifc.led_out); end
        ifc.btn = 4'd0;
        ifc.on_off = 1'b1;
        tick(2);
        exp_led_q.push_back(10'h002);
        press(4'b0010, 8, 8);
        exp_led_q.push_back(10'h002);
        ifc.btn = 4'b0010;
        budget = 0;
        while (ifc.led_out === 10'd0 && budget < 20) begin
            tick(1);
            budget++;
        end
        n_checks++; if (ifc.led_out !== 10'h002) begin n_fail++; $display("FAIL abort_wait_led: %h required 002", ifc.led_out); end
        n_checks++; if (ifc.count !== 4'd1)      begin n_fail++; $display("FAIL abort_count_mid: %0d required 1", ifc.count); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ifc.count !== 4'd0)    begin n_fail++; $display("FAIL abort_rst_count: %0d required 0", ifc.count); end
        n_checks++; if (ifc.led_out !== 10'd0) begin n_fail++; $display("FAIL abort_rst_led: %h required 0", ifc.led_out); end
        tick(1);
        ifc.btn = 4'd0;
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_level_range();
        logic [3:0] bad_lvl [2];
        logic [9:0] seen;
        bad_lvl[0] = 4'd0;
        bad_lvl[1] = 4'd11;
        for (int k = 0; k < 2; k++) begin
            restart(bad_lvl[k], 2'd1, 2'd1, 2'd1);
            seen = '0;
            ifc.btn = 4'b0010;
            for (int i = 0; i < 16; i++) begin
                if (i == 8) ifc.btn = 4'd0;
                tick(1);
                seen |= ifc.led_out;
            end
            n_checks++; if (seen !== 10'd0)     begin n_fail++; $display("FAIL lvl_idle_led: level=%0d led=%h required 0", bad_lvl[k], seen); end
            n_checks++; if (ifc.count !== 4'd0) begin n_fail++; $display("FAIL lvl_idle_count: level=%0d count=%0d required 0", bad_lvl[k], ifc.count); end
        end
        restart(4'd1, 2'd1, 2'd1, 2'd1);
        ifc.level = 4'd5;
        exp_led_q.push_back(10'h002);
        press(4'b0010, 8, 8);
        n_checks++; if (ifc.done !== 1'b1)  begin n_fail++; $display("FAIL lvl1_done: %b required 1", ifc.done); end
        n_checks++; if (ifc.count !== 4'd1) begin n_fail++; $display("FAIL lvl1_count: %0d required 1", ifc.count); end
        n_checks++; if (ifc.fail !== 1'b0)  begin n_fail++; $display("FAIL lvl1_fail: %b required 0", ifc.fail); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        rst_n      = 1'b0;
        ifc.on_off = 1'b0;
        ifc.level  = 4'd0;
        ifc.btn    = 4'd0;
        fork
            led_monitor();
        join_none
        test_reset();
        test_full_match();
        test_mismatch();
        test_bounce();
        test_multi_press();
        test_timeout();
        test_abort();
        test_level_range();
        ifc.on_off = 1'b0;
        tick(2);
        n_checks++; if (exp_led_q.size() != 0) begin n_fail++; $display("FAIL led_pending: %0d required 0", exp_led_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
